mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 201 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle RV32 control FSM with fetch/data handshakes, ack timeout and sticky trap
module mc_controller #(
  parameter int TIMEOUT = 15,
  parameter bit TRAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        alu_zero,
  output logic        ir_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t          state, state_next;
  logic [31:0]     ir;
  logic [CW-1:0]   wait_cnt;
  logic [1:0]      cause_q, cause_next;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7b5;
  logic is_load, is_store, is_opimm, is_op, is_jal, is_jalr, is_branch, is_lui, is_auipc;
  logic illegal, taken, tmo_hit, waiting;
  logic [3:0] dec_alu_op;
  logic unused_ir;

  assign opcode    = ir[6:0];
  assign f3        = ir[14:12];
  assign f7b5      = ir[30];
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_opimm  = (opcode == 7'b0010011);
  assign is_op     = (opcode == 7'b0110011);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111);
  assign is_branch = (opcode == 7'b1100011);
  assign is_lui    = (opcode == 7'b0110111);
  assign is_auipc  = (opcode == 7'b0010111);

  // funct3 010/011 has no branch meaning, so it is treated like an unknown opcode
  assign illegal = !(is_load | is_store | is_opimm | is_op | is_jal | is_jalr |
                     is_branch | is_lui | is_auipc) ||
                   (is_branch && (f3[2:1] == 2'b01));

  // a timeout of 0 disables the limit entirely
  assign tmo_hit = (TIMEOUT > 0) && (wait_cnt == TMO);
  assign waiting = ((state == S_FETCH) && !imem_ack) || ((state == S_MEM) && !dmem_ack);

  // ALU operation from the instruction class and funct fields
  always_comb begin
    dec_alu_op = 4'b0000;
    if (is_op)
      dec_alu_op = {f7b5, f3};
    else if (is_opimm)
      dec_alu_op = {(f3 == 3'b101) & f7b5, f3};
    else if (is_lui)
      dec_alu_op = 4'b1111;
    else if (is_branch) begin
      case (f3[2:1])
        2'b00:   dec_alu_op = 4'b1000;
        2'b10:   dec_alu_op = 4'b0010;
        default: dec_alu_op = 4'b0011;
      endcase
    end
  end

  // branch outcome: eq/ge/geu are taken on a zero ALU result, ne/lt/ltu on non-zero
  always_comb begin
    case (f3)
      3'b000, 3'b101, 3'b111: taken = alu_zero;
      default:                taken = !alu_zero;
    endcase
  end

  // state, instruction register, wait counter and trap cause
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      ir       <= 32'h0;
      wait_cnt <= '0;
      cause_q  <= 2'b00;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
      if (ir_we)
        ir <= imem_rdata;
      if (waiting && (TIMEOUT > 0))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  // next-state selection; an ack always beats a timeout in the same cycle
  always_comb begin
    state_next = state;
    cause_next = cause_q;
    case (state)
      S_FETCH: begin
        if (imem_ack) state_next = S_DECODE;
        else if (tmo_hit) begin
          state_next = S_TRAP;
          cause_next = 2'b10;
        end
      end
      S_DECODE: begin
        if (!illegal) state_next = S_EXEC;
        else if (TRAP_EN) begin
          state_next = S_TRAP;
          cause_next = 2'b01;
        end else state_next = S_FETCH;
      end
      S_EXEC: begin
        if (is_load || is_store) state_next = S_MEM;
        else if (is_branch)      state_next = S_FETCH;
        else                     state_next = S_WB;
      end
      S_MEM: begin
        if (dmem_ack) state_next = is_load ? S_WB : S_FETCH;
        else if (tmo_hit) begin
          state_next = S_TRAP;
          cause_next = 2'b11;
        end
      end
      S_WB:    state_next = S_FETCH;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  // strobes per state, all forced low while reset is held
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    wb_sel    = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 4'b0000;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        S_DECODE: begin
          if (illegal && !TRAP_EN) pc_we = 1'b1;
        end
        S_EXEC: begin
          alu_op    = dec_alu_op;
          alu_src_a = is_jal | is_auipc;
          alu_src_b = !(is_op | is_branch);
          if (is_branch) begin
            pc_we  = 1'b1;
            pc_sel = taken;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (is_store && dmem_ack) pc_we = 1'b1;
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          pc_sel = is_jal | is_jalr;
          wb_sel = is_load ? 2'b01 : ((is_jal | is_jalr) ? 2'b10 : 2'b00);
        end
        default: ;
      endcase
    end
  end

  assign trap       = (state == S_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - self-checking bench for mc_controller
module tb_mc_controller;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_we;
    logic       pc_we;
    logic       pc_sel;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic       trap;
    logic [1:0] trap_cause;
  } ctl_t;

  typedef struct {
    logic        ia;
    logic [31:0] rd;
    logic        da;
    logic        z;
    ctl_t        e;
    ctl_t        m;
    int          ph;
  } cyc_t;

  localparam int K_LOAD = 0, K_STORE = 1, K_OPIMM = 2, K_OP = 3, K_JAL = 4,
                 K_JALR = 5, K_BRANCH = 6, K_LUI = 7, K_AUIPC = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic imem_ack, dmem_ack, alu_zero;
  logic [31:0] imem_rdata;

  logic imem_req, dmem_req, dmem_we, ir_we, reg_we, pc_we, pc_sel, alu_src_a, alu_src_b, trap;
  logic [1:0] wb_sel, trap_cause;
  logic [3:0] alu_op;

  logic n_imem_req, n_dmem_req, n_dmem_we, n_ir_we, n_reg_we, n_pc_we, n_pc_sel;
  logic n_alu_src_a, n_alu_src_b, n_trap;
  logic [1:0] n_wb_sel, n_trap_cause;
  logic [3:0] n_alu_op;

  ctl_t obs;
  int n_chk = 0;
  int n_pass = 0;
  logic [6:0] opc_tab [0:8];

  assign obs = {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, wb_sel,
                alu_src_a, alu_src_b, alu_op, trap, trap_cause};

  always #5 clk = ~clk;

  mc_controller #(.TIMEOUT(15), .TRAP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_zero(alu_zero),
    .ir_we(ir_we), .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .trap(trap), .trap_cause(trap_cause)
  );

  mc_controller #(.TIMEOUT(15), .TRAP_EN(1'b0)) dut_nt (
    .clk(clk), .rst_n(rst_n),
    .imem_req(n_imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(n_dmem_req), .dmem_we(n_dmem_we), .dmem_ack(dmem_ack),
    .alu_zero(alu_zero),
    .ir_we(n_ir_we), .reg_we(n_reg_we), .pc_we(n_pc_we), .pc_sel(n_pc_sel), .wb_sel(n_wb_sel),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
    .trap(n_trap), .trap_cause(n_trap_cause)
  );

  // reference: ALU op from the instruction class rules
  function automatic logic [3:0] ref_alu_op(int k, logic [31:0] i);
    logic [2:0] fn;
    fn = i[14:12];
    case (k)
      K_OP:     return {i[30], fn};
      K_OPIMM:  return {(fn == 3'd5) ? i[30] : 1'b0, fn};
      K_LUI:    return 4'b1111;
      K_BRANCH: return (fn < 3'd4) ? 4'b1000 : ((fn < 3'd6) ? 4'b0010 : 4'b0011);
      default:  return 4'b0000;
    endcase
  endfunction

  // reference: beq/bge/bgeu need a zero result, bne/blt/bltu a non-zero one
  function automatic logic ref_taken(logic [2:0] fn, logic z);
    case (fn)
      3'd0, 3'd5, 3'd7: return z;
      default:          return !z;
    endcase
  endfunction

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    alu_zero = 1'b0;
    imem_rdata = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    alu_zero = 1'b0;
    imem_rdata = 32'h002081B3;
    next_cyc();
    @(negedge clk);
    n_chk++;
    if (obs !== ctl_t'(0)) $display("FAIL reset_outputs: got %h want %h", obs, ctl_t'(0));
    else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++;
    if (obs !== ctl_t'(0)) $display("FAIL reset_held: got %h want %h", obs, ctl_t'(0));
    else n_pass++;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({imem_req, ir_we, dmem_req, trap, trap_cause} !== 6'b100000)
      $display("FAIL reset_release: got %b want %b", {imem_req, ir_we, dmem_req, trap, trap_cause}, 6'b100000);
    else n_pass++;
  endtask

  task automatic test_add;
    do_reset();
    imem_ack = 1'b0;
    @(negedge clk);
    next_cyc();
    imem_ack = 1'b1;
    imem_rdata = 32'h002081B3;
    @(negedge clk);
    n_chk++;
    if ({imem_req, ir_we} !== 2'b11) $display("FAIL add_fetch_ack: got %b want 11", {imem_req, ir_we});
    else n_pass++;
    next_cyc();
    imem_ack = 1'b0;
    next_cyc();
    @(negedge clk);
    n_chk++;
    if ({alu_op, alu_src_a, alu_src_b, pc_we} !== 7'b0000_0_0_0)
      $display("FAIL add_exec: got %b want 0000000", {alu_op, alu_src_a, alu_src_b, pc_we});
    else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++;
    if ({reg_we, wb_sel, pc_we, pc_sel} !== 5'b1_00_1_0)
      $display("FAIL add_wb: got %b want 10010", {reg_we, wb_sel, pc_we, pc_sel});
    else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++;
    if ({imem_req, reg_we, pc_we} !== 3'b100) $display("FAIL add_refetch: got %b want 100", {imem_req, reg_we, pc_we});
    else n_pass++;
  endtask

  task automatic test_branch;
    do_reset();
    imem_ack = 1'b1;
    imem_rdata = 32'hFE20CEE3;
    alu_zero = 1'b0;
    next_cyc();
    imem_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({pc_we, reg_we} !== 2'b00) $display("FAIL blt_decode: got %b want 00", {pc_we, reg_we});
    else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++;
    if ({alu_op, alu_src_b, pc_we, pc_sel, reg_we} !== 8'b0010_0_1_1_0)
      $display("FAIL blt_exec: got %b want 00100110", {alu_op, alu_src_b, pc_we, pc_sel, reg_we});
    else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++;
    if ({imem_req, reg_we} !== 2'b10) $display("FAIL blt_refetch: got %b want 10", {imem_req, reg_we});
    else n_pass++;
  endtask

  task automatic test_load_wait;
    int hi;
    hi = 0;
    do_reset();
    imem_ack = 1'b1;
    imem_rdata = 32'h0000A103;
    next_cyc();
    imem_ack = 1'b0;
    next_cyc();
    @(negedge clk);
    n_chk++;
    if ({alu_op, alu_src_b} !== 5'b0000_1) $display("FAIL lw_exec: got %b want 00001", {alu_op, alu_src_b});
    else n_pass++;
    next_cyc();
    for (int c = 0; c < 4; c++) begin
      dmem_ack = (c == 3);
      @(negedge clk);
      if (dmem_req === 1'b1 && dmem_we === 1'b0 && pc_we === 1'b0) hi++;
      next_cyc();
    end
    dmem_ack = 1'b0;
    n_chk++;
    if (hi !== 4) $display("FAIL lw_req_cycles: got %0d want 4", hi);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({dmem_req, reg_we, wb_sel, pc_we, pc_sel} !== 6'b0_1_01_1_0)
      $display("FAIL lw_wb: got %b want 010110", {dmem_req, reg_we, wb_sel, pc_we, pc_sel});
    else n_pass++;
  endtask

  task automatic test_illegal;
    do_reset();
    imem_ack = 1'b1;
    imem_rdata = 32'h0000007F;
    next_cyc();
    imem_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({n_pc_we, n_pc_sel, pc_we} !== 3'b100)
      $display("FAIL ill_decode: got %b want 100", {n_pc_we, n_pc_sel, pc_we});
    else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++;
    if ({n_imem_req, n_trap} !== 2'b10) $display("FAIL ill_nop_refetch: got %b want 10", {n_imem_req, n_trap});
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      imem_ack = $urandom_range(0, 1);
      dmem_ack = $urandom_range(0, 1);
      @(negedge clk);
      n_chk++;
      if ({trap, trap_cause, imem_req, ir_we, dmem_req, reg_we, pc_we} !== 8'b1_01_00000)
        $display("FAIL ill_trap_sticky[%0d]: got %b want 10100000", c,
                 {trap, trap_cause, imem_req, ir_we, dmem_req, reg_we, pc_we});
      else n_pass++;
      next_cyc();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic test_fetch_timeout;
    int ok;
    ok = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (imem_req === 1'b1 && trap === 1'b0) ok++;
      next_cyc();
    end
    n_chk++;
    if (ok !== 16) $display("FAIL tmo_wait_cycles: got %0d want 16", ok);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({trap, trap_cause, imem_req} !== 4'b1_10_0)
      $display("FAIL tmo_trap: got %b want 1100", {trap, trap_cause, imem_req});
    else n_pass++;
  endtask

  task automatic test_ack_at_limit;
    do_reset();
    repeat (15) next_cyc();
    imem_ack = 1'b1;
    imem_rdata = 32'h002081B3;
    @(negedge clk);
    n_chk++;
    if ({ir_we, trap} !== 2'b10) $display("FAIL limit_ack: got %b want 10", {ir_we, trap});
    else n_pass++;
    next_cyc();
    imem_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({trap, trap_cause, imem_req} !== 4'b0_00_0)
      $display("FAIL limit_decode: got %b want 0000", {trap, trap_cause, imem_req});
    else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++;
    if ({trap, alu_op, alu_src_b} !== 6'b0_0000_0)
      $display("FAIL limit_exec: got %b want 000000", {trap, alu_op, alu_src_b});
    else n_pass++;
  endtask

  task automatic test_reset_mid_store;
    do_reset();
    imem_ack = 1'b1;
    imem_rdata = 32'h0020A023;
    next_cyc();
    imem_ack = 1'b0;
    next_cyc();
    next_cyc();
    @(negedge clk);
    n_chk++;
    if ({dmem_req, dmem_we} !== 2'b11) $display("FAIL sw_mem: got %b want 11", {dmem_req, dmem_we});
    else n_pass++;
    next_cyc();
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({dmem_req, pc_we, reg_we} !== 3'b000) $display("FAIL sw_abort: got %b want 000", {dmem_req, pc_we, reg_we});
    else n_pass++;
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({imem_req, dmem_req, pc_we} !== 3'b100) $display("FAIL sw_after_reset: got %b want 100", {imem_req, dmem_req, pc_we});
    else n_pass++;
  endtask

  task automatic test_random(int n);
    cyc_t tr[$];
    cyc_t c;
    ctl_t m_ctl;
    m_ctl = '1;
    m_ctl.alu_op = 4'b0;
    m_ctl.alu_src_a = 1'b0;
    m_ctl.alu_src_b = 1'b0;
    do_reset();
    for (int t = 0; t < n; t++) begin
      int k, fd, md;
      logic [31:0] ins;
      logic z;
      k = $urandom_range(0, 8);
      ins = $urandom;
      ins[6:0] = opc_tab[k];
      if (k == K_BRANCH)
        while (ins[14:13] == 2'b01) ins[14:12] = 3'($urandom_range(0, 7));
      fd = $urandom_range(0, 3);
      md = $urandom_range(0, 3);
      z = 1'($urandom_range(0, 1));
      tr.delete();
      c.rd = ins; c.z = z; c.m = m_ctl;
      for (int j = 0; j <= fd; j++) begin
        c.ia = (j == fd); c.da = 1'b0; c.e = '0; c.ph = (j == fd) ? 1 : 0;
        c.e.imem_req = 1'b1; c.e.ir_we = (j == fd);
        tr.push_back(c);
      end
      c.ia = 1'b0; c.da = 1'b0; c.e = '0; c.ph = 2;
      tr.push_back(c);
      c.e = '0; c.ph = 3; c.m = '1;
      c.e.alu_op = ref_alu_op(k, ins);
      c.e.alu_src_a = (k == K_JAL) || (k == K_AUIPC);
      c.e.alu_src_b = !((k == K_OP) || (k == K_BRANCH));
      if (k == K_BRANCH) begin
        c.e.pc_we = 1'b1;
        c.e.pc_sel = ref_taken(ins[14:12], z);
      end
      tr.push_back(c);
      c.m = m_ctl;
      if (k == K_LOAD || k == K_STORE) begin
        for (int j = 0; j <= md; j++) begin
          c.da = (j == md); c.e = '0; c.ph = (j == md) ? 5 : 4;
          c.e.dmem_req = 1'b1; c.e.dmem_we = (k == K_STORE);
          c.e.pc_we = (k == K_STORE) && (j == md);
          tr.push_back(c);
        end
        c.da = 1'b0;
      end
      if (k != K_BRANCH && k != K_STORE) begin
        c.e = '0; c.ph = 6;
        c.e.reg_we = 1'b1; c.e.pc_we = 1'b1;
        c.e.pc_sel = (k == K_JAL) || (k == K_JALR);
        c.e.wb_sel = (k == K_LOAD) ? 2'b01 : (((k == K_JAL) || (k == K_JALR)) ? 2'b10 : 2'b00);
        tr.push_back(c);
      end
      foreach (tr[j]) begin
        imem_ack = tr[j].ia;
        imem_rdata = tr[j].ia ? tr[j].rd : $urandom;
        dmem_ack = tr[j].da;
        alu_zero = tr[j].z;
        @(negedge clk);
        n_chk++;
        if (((obs ^ tr[j].e) & tr[j].m) !== ctl_t'(0))
          $display("FAIL rand[%0d] ins=%h ph=%0d: got %h want %h mask %h", t, ins, tr[j].ph, obs, tr[j].e, tr[j].m);
        else n_pass++;
        next_cyc();
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    opc_tab[K_LOAD]   = 7'b0000011;
    opc_tab[K_STORE]  = 7'b0100011;
    opc_tab[K_OPIMM]  = 7'b0010011;
    opc_tab[K_OP]     = 7'b0110011;
    opc_tab[K_JAL]    = 7'b1101111;
    opc_tab[K_JALR]   = 7'b1100111;
    opc_tab[K_BRANCH] = 7'b1100011;
    opc_tab[K_LUI]    = 7'b0110111;
    opc_tab[K_AUIPC]  = 7'b0010111;
    test_reset();
    test_add();
    test_branch();
    test_load_wait();
    test_illegal();
    test_fetch_timeout();
    test_ack_at_limit();
    test_reset_mid_store();
    test_random(60);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
